// File: rtl/uart_rx_fifo.sv
// UART receiver: 2-flop synchronizer, oversampled bit-recovery FSM with optional parity,
// sticky error flags and a show-ahead receive FIFO.
module uart_rx_fifo #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 19200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                               CLK100MHZ,
    input  logic                               SWITCH_RESET,
    input  logic                               RX_INPUT,
    input  logic                               rd_en,
    input  logic                               err_clr,
    output logic [DATA_BITS-1:0]               rd_data,
    output logic                               empty,
    output logic                               full,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    count,
    output logic                               frame_err,
    output logic                               parity_err,
    output logic                               overrun_err
);

    // state  | meaning
    // IDLE   | line idle, waiting for a synchronized 0
    // START  | confirming the start bit at its midpoint
    // DATA   | sampling DATA_BITS data bits, LSB first
    // PAR    | sampling the parity bit
    // STOP   | sampling STOP_BITS stop bits; frame completes on the last one
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

    localparam int DIV_RAW = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW      = $clog2(OVERSAMPLE);
    localparam int BW      = $clog2(DATA_BITS);
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int CW      = $clog2(FIFO_DEPTH+1);

    logic              sync1_q, sync2_q, rx_s;
    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic              tick;

    state_t            state_q, state_d;
    logic [SW-1:0]     scnt_q, scnt_d;
    logic [BW-1:0]     bcnt_q, bcnt_d;
    logic              stop_cnt_q, stop_cnt_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic              frm_bad_q, frm_bad_d;
    logic              par_bad_q, par_bad_d;
    logic              done, done_fe, done_pe;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              fe_q, fe_d, pe_q, pe_d, oe_q, oe_d;
    logic              push, pop, good, full_int, empty_int;

    assign rx_s = sync2_q;

    // Free-running divider: down-counts to zero, then reloads
    always_comb begin
        tick      = (div_cnt_q == '0);
        div_cnt_d = tick ? DIV_W'(DIV-1) : div_cnt_q - DIV_W'(1);
    end

    always_comb begin
        state_d    = state_q;
        scnt_d     = scnt_q;
        bcnt_d     = bcnt_q;
        stop_cnt_d = stop_cnt_q;
        shreg_d    = shreg_q;
        frm_bad_d  = frm_bad_q;
        par_bad_d  = par_bad_q;
        done       = 1'b0;
        done_fe    = 1'b0;
        done_pe    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!rx_s) begin
                    state_d = S_START;
                    scnt_d  = '0;
                end
            end
            S_START: begin
                if (tick) begin
                    if (scnt_q == SW'(OVERSAMPLE/2-1)) begin
                        scnt_d = '0;
                        bcnt_d = '0;
                        state_d = rx_s ? S_IDLE : S_DATA;
                    end else begin
                        scnt_d = scnt_q + SW'(1);
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    if (scnt_q == SW'(OVERSAMPLE-1)) begin
                        scnt_d  = '0;
                        shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
                        if (bcnt_q == BW'(DATA_BITS-1)) begin
                            state_d    = (PARITY != 0) ? S_PAR : S_STOP;
                            stop_cnt_d = 1'b0;
                            frm_bad_d  = 1'b0;
                            par_bad_d  = 1'b0;
                        end else begin
                            bcnt_d = bcnt_q + BW'(1);
                        end
                    end else begin
                        scnt_d = scnt_q + SW'(1);
                    end
                end
            end
            S_PAR: begin
                if (tick) begin
                    if (scnt_q == SW'(OVERSAMPLE-1)) begin
                        scnt_d    = '0;
                        par_bad_d = (PARITY == 1) ? ~(^shreg_q ^ rx_s) : (^shreg_q ^ rx_s);
                        state_d   = S_STOP;
                    end else begin
                        scnt_d = scnt_q + SW'(1);
                    end
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (scnt_q == SW'(OVERSAMPLE-1)) begin
                        scnt_d = '0;
                        if (stop_cnt_q == 1'(STOP_BITS-1)) begin
                            done    = 1'b1;
                            done_fe = frm_bad_q | ~rx_s;
                            done_pe = par_bad_q;
                            state_d = S_IDLE;
                        end else begin
                            stop_cnt_d = 1'b1;
                            frm_bad_d  = frm_bad_q | ~rx_s;
                        end
                    end else begin
                        scnt_d = scnt_q + SW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A full FIFO that pops this cycle has room, so overrun only counts a non-popping full FIFO
    always_comb begin
        empty_int = (count_q == '0);
        full_int  = (count_q == CW'(FIFO_DEPTH));
        pop       = rd_en & ~empty_int;
        good      = done & ~done_fe & ~done_pe;
        push      = good & ~(full_int & ~pop);
        wr_ptr_d  = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d   = count_q;
        if (push && !pop)      count_d = count_q + CW'(1);
        else if (pop && !push) count_d = count_q - CW'(1);
        fe_d = done_fe | (fe_q & ~err_clr);
        pe_d = done_pe | (pe_q & ~err_clr);
        oe_d = (good & full_int & ~pop) | (oe_q & ~err_clr);
    end

    always_ff @(posedge CLK100MHZ or negedge SWITCH_RESET) begin
        if (!SWITCH_RESET) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            div_cnt_q  <= '0;
            state_q    <= S_IDLE;
            scnt_q     <= '0;
            bcnt_q     <= '0;
            stop_cnt_q <= 1'b0;
            shreg_q    <= '0;
            frm_bad_q  <= 1'b0;
            par_bad_q  <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            fe_q       <= 1'b0;
            pe_q       <= 1'b0;
            oe_q       <= 1'b0;
        end else begin
            sync1_q    <= RX_INPUT;
            sync2_q    <= sync1_q;
            div_cnt_q  <= div_cnt_d;
            state_q    <= state_d;
            scnt_q     <= scnt_d;
            bcnt_q     <= bcnt_d;
            stop_cnt_q <= stop_cnt_d;
            shreg_q    <= shreg_d;
            frm_bad_q  <= frm_bad_d;
            par_bad_q  <= par_bad_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            fe_q       <= fe_d;
            pe_q       <= pe_d;
            oe_q       <= oe_d;
        end
    end

    always_ff @(posedge CLK100MHZ) begin
        if (push) mem[wr_ptr_q] <= shreg_q;
    end

    assign rd_data     = empty_int ? '0 : mem[rd_ptr_q];
    assign empty       = empty_int;
    assign full        = full_int;
    assign count       = count_q;
    assign frame_err   = fe_q;
    assign parity_err  = pe_q;
    assign overrun_err = oe_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: one 8N1 instance and one 8E1 instance, 16 clocks per bit.
module tb_uart_rx_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       rx0, rd_en0, err_clr0;
    logic [7:0] rd_data0;
    logic       empty0, full0, fe0, pe0, oe0;
    logic [2:0] count0;
    logic       rx1, rd_en1, err_clr1;
    logic [7:0] rd_data1;
    logic       empty1, full1, fe1, pe1, oe1;
    logic [2:0] count1;

    int n_checks = 0;
    int n_fail   = 0;

    uart_rx_fifo #(.CLK_FREQ(1_600_000), .BAUD(100_000), .OVERSAMPLE(16), .DATA_BITS(8),
                   .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut (
        .CLK100MHZ(clk), .SWITCH_RESET(rst_n), .RX_INPUT(rx0), .rd_en(rd_en0),
        .err_clr(err_clr0), .rd_data(rd_data0), .empty(empty0), .full(full0),
        .count(count0), .frame_err(fe0), .parity_err(pe0), .overrun_err(oe0));

    uart_rx_fifo #(.CLK_FREQ(1_600_000), .BAUD(100_000), .OVERSAMPLE(16), .DATA_BITS(8),
                   .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut_p (
        .CLK100MHZ(clk), .SWITCH_RESET(rst_n), .RX_INPUT(rx1), .rd_en(rd_en1),
        .err_clr(err_clr1), .rd_data(rd_data1), .empty(empty1), .full(full1),
        .count(count1), .frame_err(fe1), .parity_err(pe1), .overrun_err(oe1));

    typedef struct {
        logic [7:0] d;
        logic       stop;
        logic       clr;
        logic       exp_empty;
        logic [2:0] exp_count;
        logic       exp_full;
        logic [7:0] exp_data;
        logic       exp_fe;
        logic       exp_oe;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_line(input int which, input logic v);
        if (which == 0) rx0 = v;
        else            rx1 = v;
    endtask

    task automatic drive_bit(input int which, input logic v);
        set_line(which, v);
        repeat (16) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int which, input logic [7:0] d, input bit use_par,
                              input logic par_bit, input logic stop_bit);
        @(posedge clk);
        #1;
        drive_bit(which, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(which, d[i]);
        if (use_par) drive_bit(which, par_bit);
        drive_bit(which, stop_bit);
        set_line(which, 1'b1);
    endtask

    task automatic pulse_rd0();
        rd_en0 = 1'b1;
        @(posedge clk);
        #1;
        rd_en0 = 1'b0;
    endtask

    task automatic pulse_clr0();
        err_clr0 = 1'b1;
        @(posedge clk);
        #1;
        err_clr0 = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [7:0] exp_q [4];

        vecs[0] = '{8'h3C, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[1] = '{8'h11, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 8'h11, 1'b0, 1'b0};
        vecs[2] = '{8'h22, 1'b1, 1'b0, 1'b0, 3'd2, 1'b0, 8'h11, 1'b0, 1'b0};
        vecs[3] = '{8'h33, 1'b1, 1'b0, 1'b0, 3'd3, 1'b0, 8'h11, 1'b0, 1'b0};
        vecs[4] = '{8'h44, 1'b1, 1'b0, 1'b0, 3'd4, 1'b1, 8'h11, 1'b0, 1'b0};
        vecs[5] = '{8'h55, 1'b1, 1'b0, 1'b0, 3'd4, 1'b1, 8'h11, 1'b0, 1'b1};
        vecs[6] = '{8'h55, 1'b1, 1'b0, 1'b0, 3'd4, 1'b1, 8'h11, 1'b0, 1'b1};

        rst_n = 1'b0;
        rx0 = 1'b1; rd_en0 = 1'b0; err_clr0 = 1'b0;
        rx1 = 1'b1; rd_en1 = 1'b0; err_clr1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_empty", 32'(empty0), 32'd1);
        check("reset_full", 32'(full0), 32'd0);
        check("reset_count", 32'(count0), 32'd0);
        check("reset_rd_data", 32'(rd_data0), 32'd0);
        check("reset_flags", {29'd0, fe0, pe0, oe0}, 32'd0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // 0xA5 8N1 with latency measured from the start edge
        lat = 0;
        fork
            send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1);
            begin
                @(posedge clk);
                while (empty0 && lat < 200) begin
                    @(posedge clk);
                    #1;
                    lat++;
                end
            end
        join
        check("latency_in_148_160", 32'(lat >= 148 && lat <= 160), 32'd1);
        check("a5_data", 32'(rd_data0), 32'hA5);
        check("a5_count", 32'(count0), 32'd1);
        pulse_rd0();
        check("a5_pop_empty", 32'(empty0), 32'd1);
        check("a5_pop_count", 32'(count0), 32'd0);

        // 4-clock low glitch must be rejected
        rx0 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rx0 = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check("glitch_empty", 32'(empty0), 32'd1);
        check("glitch_flags", {29'd0, fe0, pe0, oe0}, 32'd0);

        // Table: frame error, fill to full, overrun
        for (int i = 0; i < 6; i++) begin
            send_frame(0, vecs[i].d, 1'b0, 1'b0, vecs[i].stop);
            repeat (2) @(posedge clk);
            #1;
            check($sformatf("v%0d_empty", i), 32'(empty0), 32'(vecs[i].exp_empty));
            check($sformatf("v%0d_count", i), 32'(count0), 32'(vecs[i].exp_count));
            check($sformatf("v%0d_full", i), 32'(full0), 32'(vecs[i].exp_full));
            check($sformatf("v%0d_frame_err", i), 32'(fe0), 32'(vecs[i].exp_fe));
            check($sformatf("v%0d_overrun", i), 32'(oe0), 32'(vecs[i].exp_oe));
            if (!vecs[i].exp_empty)
                check($sformatf("v%0d_rd_data", i), 32'(rd_data0), 32'(vecs[i].exp_data));
            if (vecs[i].clr) begin
                pulse_clr0();
                check($sformatf("v%0d_clr_fe", i), 32'(fe0), 32'd0);
            end
        end

        // Clear overrun, then push onto a full FIFO with a pop in the push cycle
        pulse_clr0();
        check("oe_cleared", 32'(oe0), 32'd0);
        fork
            send_frame(0, 8'h66, 1'b0, 1'b0, 1'b1);
            begin
                @(posedge clk);
                repeat (154) @(posedge clk);
                #1;
                rd_en0 = 1'b1;
                @(posedge clk);
                #1;
                rd_en0 = 1'b0;
            end
        join
        check("pushpop_full_oe", 32'(oe0), 32'd0);
        check("pushpop_full_count", 32'(count0), 32'd4);
        check("pushpop_full_full", 32'(full0), 32'd1);
        exp_q = '{8'h22, 8'h33, 8'h44, 8'h66};
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain%0d", i), 32'(rd_data0), 32'(exp_q[i]));
            pulse_rd0();
        end
        check("drain_empty", 32'(empty0), 32'd1);

        // Reset in the middle of a frame with data and an error flag pending
        send_frame(0, 8'h77, 1'b0, 1'b0, 1'b1);
        send_frame(0, 8'h00, 1'b0, 1'b0, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        check("pre_reset_fe", 32'(fe0), 32'd1);
        check("pre_reset_count", 32'(count0), 32'd1);
        rx0 = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        rx0 = 1'b1;
        repeat (24) @(posedge clk);
        #1;
        rx0 = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        rx0 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("midreset_empty", 32'(empty0), 32'd1);
        check("midreset_count", 32'(count0), 32'd0);
        check("midreset_flags", {29'd0, fe0, pe0, oe0}, 32'd0);
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check("post_reset_idle_empty", 32'(empty0), 32'd1);
        send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check("post_reset_5a_data", 32'(rd_data0), 32'h5A);
        check("post_reset_5a_count", 32'(count0), 32'd1);
        check("post_reset_5a_fe", 32'(fe0), 32'd0);

        // Even parity instance
        send_frame(1, 8'h07, 1'b1, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check("par_bad_pe", 32'(pe1), 32'd1);
        check("par_bad_empty", 32'(empty1), 32'd1);
        check("par_bad_fe", 32'(fe1), 32'd0);
        send_frame(1, 8'h07, 1'b1, 1'b1, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check("par_good_data", 32'(rd_data1), 32'h07);
        check("par_good_count", 32'(count1), 32'd1);
        check("par_sticky", 32'(pe1), 32'd1);
        err_clr1 = 1'b1;
        @(posedge clk);
        #1;
        err_clr1 = 1'b0;
        check("par_cleared", 32'(pe1), 32'd0);
        send_frame(1, 8'h03, 1'b1, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check("par_even0_count", 32'(count1), 32'd2);
        check("par_even0_pe", 32'(pe1), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
